// File: rtl/gshare_pkg.sv
// Shared constants and helpers for the gshare branch predictor: counter reset value,
// saturating counter step and table index hash.
package gshare_pkg;

  // Weakly-taken reset value for a counter of the given width.
  function automatic logic [31:0] ctr_init(input int bits);
    return 32'd1 << (bits - 1);
  endfunction

  function automatic logic [31:0] ctr_next(input logic [31:0] ctr, input logic taken,
                                           input int bits);
    logic [31:0] max_v;
    max_v = (32'd1 << bits) - 32'd1;
    if (taken && (ctr != max_v))
      return ctr + 32'd1;
    else if (!taken && (ctr != 32'd0))
      return ctr - 32'd1;
    else
      return ctr;
  endfunction

  // Word-aligned PC bits select the entry; gshare folds in the zero-extended history.
  function automatic logic [31:0] calc_idx(input logic [31:0] pc, input logic [31:0] ghr,
                                           input logic gshare, input int idx_bits);
    logic [31:0] mask;
    logic [31:0] pc_idx;
    mask   = (32'd1 << idx_bits) - 32'd1;
    pc_idx = (pc >> 2) & mask;
    return gshare ? (pc_idx ^ ghr) : pc_idx;
  endfunction

endpackage

// File: rtl/gshare_predictor_sat_counter.sv
// One saturating direction counter of the predictor table; resets to weakly taken.
module bp_sat_counter
  import gshare_pkg::*;
#(
  parameter int CTR_BITS = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic                taken,
  output logic [CTR_BITS-1:0] ctr
);

  localparam logic [31:0]         INIT_W = ctr_init(CTR_BITS);
  localparam logic [CTR_BITS-1:0] INIT   = INIT_W[CTR_BITS-1:0];

  logic [31:0] next_w;
  logic        unused_bits;

  always_comb next_w = ctr_next(32'(ctr), taken, CTR_BITS);

  assign unused_bits = ^next_w;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      ctr <= INIT;
    else if (en)
      ctr <= next_w[CTR_BITS-1:0];
  end

endmodule

// File: rtl/gshare_predictor.sv
// Bimodal/gshare branch predictor: counter table, non-speculative global history,
// registered one-cycle lookup and a saturating mispredict counter.
module gshare_predictor
  import gshare_pkg::*;
#(
  parameter int PC_BITS   = 32,
  parameter int IDX_BITS  = 4,
  parameter int CTR_BITS  = 2,
  parameter int HIST_BITS = 4,
  parameter int MODE      = 1,
  parameter int CNT_BITS  = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req,
  input  logic [PC_BITS-1:0]   req_pc,
  output logic                 pred_valid,
  output logic                 pred_taken,
  output logic [IDX_BITS-1:0]  pred_idx,
  input  logic                 upd_valid,
  input  logic [IDX_BITS-1:0]  upd_idx,
  input  logic                 upd_taken,
  input  logic                 upd_pred,
  output logic [HIST_BITS-1:0] ghr,
  output logic [CNT_BITS-1:0]  mispred_cnt
);

  localparam int DEPTH = 1 << IDX_BITS;

  logic [CTR_BITS-1:0]  ctr_q [DEPTH];
  logic [31:0]          pc_ext;
  logic [31:0]          ghr_ext;
  logic [31:0]          idx_wide;
  logic [IDX_BITS-1:0]  lookup_idx;
  logic [CTR_BITS-1:0]  lookup_ctr;
  logic [HIST_BITS-1:0] ghr_next;
  logic                 unused_bits;

  genvar i;
  generate
    for (i = 0; i < DEPTH; i++) begin : g_table
      bp_sat_counter #(.CTR_BITS(CTR_BITS)) u_ctr (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (upd_valid && (upd_idx == IDX_BITS'(i))),
        .taken (upd_taken),
        .ctr   (ctr_q[i])
      );
    end
  endgenerate

  // The index uses the history as it stands this cycle, before any same-edge shift.
  always_comb begin
    pc_ext                  = '0;
    pc_ext[IDX_BITS+1:0]    = req_pc[IDX_BITS+1:0];
    ghr_ext                 = '0;
    ghr_ext[HIST_BITS-1:0]  = ghr;
    idx_wide                = calc_idx(pc_ext, ghr_ext, MODE != 0, IDX_BITS);
    lookup_idx              = idx_wide[IDX_BITS-1:0];
    lookup_ctr              = ctr_q[lookup_idx];
  end

  assign unused_bits = ^{req_pc, idx_wide};

  generate
    if (HIST_BITS == 1) begin : g_hist1
      assign ghr_next = upd_taken;
    end else begin : g_histn
      assign ghr_next = {ghr[HIST_BITS-2:0], upd_taken};
    end
  endgenerate

  // Lookup register: the table is read before this edge's update lands.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pred_valid <= 1'b0;
      pred_taken <= 1'b0;
      pred_idx   <= '0;
    end else begin
      pred_valid <= req;
      if (req) begin
        pred_taken <= lookup_ctr[CTR_BITS-1];
        pred_idx   <= lookup_idx;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      ghr <= '0;
    else if (upd_valid)
      ghr <= ghr_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      mispred_cnt <= '0;
    else if (upd_valid && (upd_pred != upd_taken) && (mispred_cnt != '1))
      mispred_cnt <= mispred_cnt + CNT_BITS'(1);
  end

endmodule

// File: tb/tb_gshare_predictor.sv
// Directed bench for gshare_predictor: a bimodal instance with a 4-bit mispredict
// counter and a default gshare instance share the same stimulus.
module tb_gshare_predictor;

  typedef struct {
    logic        req;
    logic [31:0] pc;
    logic        uv;
    logic [3:0]  ui;
    logic        ut;
    logic        up;
    logic        ev;
    logic        et;
    logic [3:0]  ei;
    logic [3:0]  eg;
    logic [3:0]  ec;
  } vec_t;

  logic        clk;
  logic        rst_n;
  logic        req;
  logic [31:0] req_pc;
  logic        upd_valid;
  logic [3:0]  upd_idx;
  logic        upd_taken;
  logic        upd_pred;

  logic        pv0, pt0, pv1, pt1;
  logic [3:0]  pi0, pi1, ghr0, ghr1;
  logic [3:0]  cnt0;
  logic [15:0] cnt1;

  int checks = 0;
  int errors = 0;
  vec_t vecs[13];

  gshare_predictor #(.MODE(0), .CNT_BITS(4)) dut0 (
    .clk(clk), .rst_n(rst_n), .req(req), .req_pc(req_pc),
    .pred_valid(pv0), .pred_taken(pt0), .pred_idx(pi0),
    .upd_valid(upd_valid), .upd_idx(upd_idx), .upd_taken(upd_taken), .upd_pred(upd_pred),
    .ghr(ghr0), .mispred_cnt(cnt0)
  );

  gshare_predictor #(.MODE(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .req(req), .req_pc(req_pc),
    .pred_valid(pv1), .pred_taken(pt1), .pred_idx(pi1),
    .upd_valid(upd_valid), .upd_idx(upd_idx), .upd_taken(upd_taken), .upd_pred(upd_pred),
    .ghr(ghr1), .mispred_cnt(cnt1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs at the falling edge and return just after the rising edge.
  task automatic step(input logic r, input logic [31:0] pc, input logic uv,
                      input logic [3:0] ui, input logic ut, input logic up);
    @(negedge clk);
    req = r; req_pc = pc; upd_valid = uv; upd_idx = ui; upd_taken = ut; upd_pred = up;
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input vec_t v);
    step(v.req, v.pc, v.uv, v.ui, v.ut, v.up);
  endtask

  task automatic idle();
    step(1'b0, 32'h0, 1'b0, 4'h0, 1'b0, 1'b0);
  endtask

  task automatic doReset();
    @(negedge clk);
    req = 1'b0; upd_valid = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b1; req = 1'b0; req_pc = '0;
    upd_valid = 1'b0; upd_idx = '0; upd_taken = 1'b0; upd_pred = 1'b0;

    // req, pc, uv, ui, ut, up, exp_valid, exp_taken, exp_idx, exp_ghr, exp_cnt
    vecs[0]  = '{1'b0, 32'h00, 1'b1, 4'h5, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 4'h0};
    vecs[1]  = '{1'b0, 32'h00, 1'b1, 4'h5, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 4'h0};
    vecs[2]  = '{1'b0, 32'h00, 1'b1, 4'h5, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 4'h0};
    vecs[3]  = '{1'b1, 32'h14, 1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0, 4'h5, 4'h0, 4'h0};
    vecs[4]  = '{1'b0, 32'h00, 1'b1, 4'h5, 1'b1, 1'b0, 1'b0, 1'b0, 4'h5, 4'h1, 4'h1};
    vecs[5]  = '{1'b1, 32'h14, 1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0, 4'h5, 4'h1, 4'h1};
    vecs[6]  = '{1'b0, 32'h00, 1'b1, 4'h5, 1'b1, 1'b1, 1'b0, 1'b0, 4'h5, 4'h3, 4'h1};
    vecs[7]  = '{1'b0, 32'h00, 1'b1, 4'h5, 1'b1, 1'b1, 1'b0, 1'b0, 4'h5, 4'h7, 4'h1};
    vecs[8]  = '{1'b0, 32'h00, 1'b1, 4'h5, 1'b1, 1'b1, 1'b0, 1'b0, 4'h5, 4'hF, 4'h1};
    vecs[9]  = '{1'b1, 32'h14, 1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b1, 4'h5, 4'hF, 4'h1};
    vecs[10] = '{1'b0, 32'h00, 1'b1, 4'h3, 1'b0, 1'b0, 1'b0, 1'b1, 4'h5, 4'hE, 4'h1};
    vecs[11] = '{1'b1, 32'h0C, 1'b1, 4'h3, 1'b1, 1'b1, 1'b1, 1'b0, 4'h3, 4'hD, 4'h1};
    vecs[12] = '{1'b1, 32'h0C, 1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b1, 4'h3, 4'hD, 4'h1};

    // Asynchronous reset takes effect before any clock edge.
    #2 rst_n = 1'b0;
    #1;
    checkOutput("reset pred_valid", 32'(pv0), 32'h0);
    checkOutput("reset pred_taken", 32'(pt0), 32'h0);
    checkOutput("reset pred_idx", 32'(pi0), 32'h0);
    checkOutput("reset ghr", 32'(ghr1), 32'h0);
    checkOutput("reset mispred_cnt", 32'(cnt1), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, 32'h0, 1'b0, 4'h0, 1'b0, 1'b0);
    checkOutput("first lookup valid bimodal", 32'(pv0), 32'h1);
    checkOutput("first lookup taken bimodal", 32'(pt0), 32'h1);
    checkOutput("first lookup idx bimodal", 32'(pi0), 32'h0);
    checkOutput("first lookup valid gshare", 32'(pv1), 32'h1);
    checkOutput("first lookup taken gshare", 32'(pt1), 32'h1);
    checkOutput("first lookup idx gshare", 32'(pi1), 32'h0);
    checkOutput("first lookup ghr", 32'(ghr0), 32'h0);
    checkOutput("first lookup mispred_cnt", 32'(cnt0), 32'h0);

    // Saturation and same-cycle collision on the bimodal instance.
    doReset();
    for (int i = 0; i < 13; i++) begin
      applyStimulus(vecs[i]);
      checkOutput($sformatf("vec%0d pred_valid", i), 32'(pv0), 32'(vecs[i].ev));
      checkOutput($sformatf("vec%0d pred_taken", i), 32'(pt0), 32'(vecs[i].et));
      checkOutput($sformatf("vec%0d pred_idx", i), 32'(pi0), 32'(vecs[i].ei));
      checkOutput($sformatf("vec%0d ghr", i), 32'(ghr0), 32'(vecs[i].eg));
      checkOutput($sformatf("vec%0d mispred_cnt", i), 32'(cnt0), 32'(vecs[i].ec));
    end

    // Gshare hashing with history T,N,T,N.
    doReset();
    step(1'b0, 32'h0, 1'b1, 4'h0, 1'b1, 1'b1);
    step(1'b0, 32'h0, 1'b1, 4'h0, 1'b0, 1'b0);
    step(1'b0, 32'h0, 1'b1, 4'h0, 1'b1, 1'b1);
    step(1'b0, 32'h0, 1'b1, 4'h0, 1'b0, 1'b0);
    checkOutput("gshare ghr TNTN", 32'(ghr1), 32'hA);
    step(1'b1, 32'h0, 1'b0, 4'h0, 1'b0, 1'b0);
    checkOutput("gshare idx pc 0x0", 32'(pi1), 32'hA);
    checkOutput("gshare taken pc 0x0", 32'(pt1), 32'h1);
    step(1'b1, 32'h28, 1'b0, 4'h0, 1'b0, 1'b0);
    checkOutput("gshare idx pc 0x28", 32'(pi1), 32'h0);
    step(1'b1, 32'h0, 1'b1, 4'h1, 1'b1, 1'b1);
    checkOutput("gshare idx uses pre-shift ghr", 32'(pi1), 32'hA);
    checkOutput("gshare ghr after shift", 32'(ghr1), 32'h5);

    // Mispredict counter: saturates on the 4-bit instance only.
    doReset();
    for (int i = 0; i < 3; i++) step(1'b0, 32'h0, 1'b1, 4'h2, 1'b0, 1'b1);
    checkOutput("mispred after 3", 32'(cnt0), 32'h3);
    step(1'b0, 32'h0, 1'b1, 4'h2, 1'b0, 1'b0);
    checkOutput("mispred correct holds", 32'(cnt0), 32'h3);
    for (int i = 0; i < 20; i++) step(1'b0, 32'h0, 1'b1, 4'h2, 1'b1, 1'b0);
    checkOutput("mispred saturated", 32'(cnt0), 32'hF);
    checkOutput("mispred wide counter", 32'(cnt1), 32'd23);
    step(1'b0, 32'h0, 1'b1, 4'h2, 1'b1, 1'b1);
    checkOutput("mispred saturated correct holds", 32'(cnt0), 32'hF);

    // Reset in the middle of an in-flight prediction.
    doReset();
    step(1'b0, 32'h0, 1'b1, 4'h5, 1'b0, 1'b0);
    step(1'b0, 32'h0, 1'b1, 4'h5, 1'b0, 1'b0);
    step(1'b0, 32'h0, 1'b1, 4'h0, 1'b1, 1'b1);
    step(1'b0, 32'h0, 1'b1, 4'h0, 1'b1, 1'b1);
    step(1'b0, 32'h0, 1'b1, 4'h0, 1'b0, 1'b0);
    checkOutput("midreset ghr before", 32'(ghr0), 32'h6);
    step(1'b1, 32'h14, 1'b0, 4'h0, 1'b0, 1'b0);
    checkOutput("midreset valid before", 32'(pv0), 32'h1);
    checkOutput("midreset taken before", 32'(pt0), 32'h0);
    #1 rst_n = 1'b0;
    #1;
    checkOutput("midreset valid dropped", 32'(pv0), 32'h0);
    checkOutput("midreset ghr cleared", 32'(ghr0), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, 32'h14, 1'b0, 4'h0, 1'b0, 1'b0);
    checkOutput("midreset taken after", 32'(pt0), 32'h1);
    checkOutput("midreset idx after", 32'(pi0), 32'h5);
    idle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/gshare_predictor.md
Name: gshare_predictor

Overview:
- Parametrised successor to the single-counter branch predictor.
- Holds a table of 2^IDX_BITS saturating counters, indexed by PC bits, optionally XORed with a global history register (GHR).
- Lookup and update run on separate ports, so a resolved branch can train the table in the same cycle a new branch is looked up.
- Sits beside fetch: fetch issues lookups, and the execute stage returns the resolved outcome together with the index it was given at lookup.

Parameters:
- PC_BITS, 32: width of req_pc.
- IDX_BITS, 4: log2 of the table depth. Must satisfy IDX_BITS+2 <= PC_BITS.
- CTR_BITS, 2: width of each saturating counter. Must be >= 2.
- HIST_BITS, 4: GHR width. Must satisfy 1 <= HIST_BITS <= IDX_BITS.
- MODE, 1: 0 = bimodal (PC only); 1 = gshare (PC XOR GHR).
- CNT_BITS, 16: width of the mispredict counter.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- req  in  1  lookup request
- req_pc  in  PC_BITS  branch PC for the lookup
- pred_valid  out  1  prediction valid, one cycle after req
- pred_taken  out  1  predicted direction
- pred_idx  out  IDX_BITS  table index used; returned later on upd_idx
- upd_valid  in  1  resolved-branch update
- upd_idx  in  IDX_BITS  index to train
- upd_taken  in  1  actual outcome
- upd_pred  in  1  direction that was predicted for this branch
- ghr  out  HIST_BITS  current global history
- mispred_cnt  out  CNT_BITS  saturating count of mispredicts

Behaviour:
- Reset (async, rst_n=0):
  - every counter is set to INIT = 2^(CTR_BITS-1), i.e. weakly taken;
  - ghr=0, pred_valid=0, pred_taken=0, pred_idx=0, mispred_cnt=0;
  - outputs change immediately on reset assertion, without waiting for clk.
- Index computation:
  - pc_idx = req_pc[IDX_BITS+1:2];
  - MODE=0: idx = pc_idx;
  - MODE=1: idx = pc_idx XOR zero-extended ghr.
  - ghr is sampled in the req cycle, before any same-cycle shift.
- Lookup:
  - latency is 1 cycle. On the edge where req=1: pred_valid<=1, pred_idx<=idx, pred_taken<=MSB of table[idx].
  - On an edge where req=0: pred_valid<=0, and pred_taken/pred_idx hold their previous values.
  - Back-to-back requests are accepted every cycle.
- Update, on the edge where upd_valid=1:
  - table[upd_idx] saturates up when upd_taken=1 (max 2^CTR_BITS-1) and down when upd_taken=0 (min 0);
  - ghr <= {ghr[HIST_BITS-2:0], upd_taken}; when HIST_BITS=1, ghr <= upd_taken. GHR is therefore non-speculative;
  - if upd_pred != upd_taken, mispred_cnt increments and saturates at all-ones.
- Simultaneous req and upd_valid:
  - the lookup is read-before-write: the prediction reflects the counter value before the update;
  - the index uses the pre-shift ghr;
  - both actions complete on the same edge.
- No back-pressure. Index bounds are guaranteed by the parameter constraints.
- Reset mid-operation: any in-flight prediction is dropped (pred_valid=0) and all state returns to the reset values.

Decomposition:
- Package gshare_pkg holds:
  - the INIT constant;
  - function ctr_next(ctr, taken), implementing saturating increment/decrement;
  - function calc_idx(pc, ghr, mode).
- Sub-module bp_sat_counter: one CTR_BITS counter with async reset to INIT, an update enable, and the taken input. It is instantiated 2^IDX_BITS times via generate. The top level holds the GHR, the lookup register and the mispredict counter.

Test Plan:
1. Reset: release rst_n, then req with req_pc=0x0 -> next cycle pred_valid=1, pred_taken=1, pred_idx=0; ghr=0 and mispred_cnt=0.
2. Saturation down/up (MODE=0):
   - 3 updates to upd_idx=5 with upd_taken=0 -> counter 2,1,0,0; req_pc=0x14 -> pred_taken=0, pred_idx=5;
   - then 1 taken update -> counter=1, pred_taken still 0;
   - then 3 more taken updates -> counter=3, pred_taken=1.
3. Gshare hashing (MODE=1): updates with taken sequence T,N,T,N -> ghr=4'b1010; req_pc=0x0 -> pred_idx=0xA; req_pc=0x28 -> pred_idx=0x0.
4. Collision (MODE=0): counter[3]=1; in the same cycle, req with req_pc=0xC and upd_valid with upd_idx=3, upd_taken=1 -> pred_taken=0 (old value); the next req to the same PC -> pred_taken=1.
5. Mispredict counter (CNT_BITS=4): 3 updates with upd_pred=1, upd_taken=0 -> mispred_cnt=3; 20 mispredicts -> mispred_cnt=15 (held); an update with upd_pred == upd_taken leaves the count unchanged.
6. Reset mid-stream: rst_n=0 asynchronously while pred_valid=1, with counter[5]=0 and ghr=4'b0110 -> pred_valid=0 and ghr=0 immediately; after release, req_pc=0x14 (MODE=0) -> pred_taken=1.
